// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: FSM states, acknowledge codes
// and the word-count range check.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_ACK  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    localparam logic [7:0] ACK_OK  = 8'hAA;
    localparam logic [7:0] ACK_ERR = 8'hEE;

    // Widened by one bit so a count of exactly 2^aw is still representable.
    function automatic logic len_too_big(input logic [31:0] n, input int unsigned aw);
        return {1'b0, n} > (33'd1 << aw);
    endfunction

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Big-endian byte-to-word packer: shift register plus 2-bit byte counter.
// word_full flags the 4th byte combinationally; word_next is the completed word.
module byte_packer (
    input  logic        clk,
    input  logic        srst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [31:0] word_reg;
    logic [1:0]  cnt_reg;

    // Each lane takes the byte from the lane below; lane 0 takes the new byte.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        if (gi == 0) begin : g_first
            assign word_next[7:0] = byte_data;
        end else begin : g_shift
            assign word_next[8*gi +: 8] = word_reg[8*(gi-1) +: 8];
        end
    end

    assign word_full = byte_valid && (cnt_reg == 2'd3);

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            word_reg <= '0;
            cnt_reg  <= '0;
        end else if (byte_valid) begin
            word_reg <= word_next;
            cnt_reg  <= cnt_reg + 2'd1;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Serial instruction loader: receives a big-endian word count and instruction
// words over a byte stream, writes them to instruction memory, then acknowledges.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t              state_reg, state_next;
    logic [31:0]         count_reg;
    logic [31:0]         written_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [31:0]         wdata_reg;
    logic                we_reg;
    logic                err_reg;
    logic [7:0]          code_reg;

    logic        pk_valid;
    logic        pk_clear;
    logic [31:0] word_next;
    logic        word_full;
    logic        too_big;
    logic        last_write;

    assign pk_valid   = rx_valid && (state_reg == ST_LEN || state_reg == ST_DATA);
    assign pk_clear   = start && (state_reg == ST_IDLE || state_reg == ST_FIN);
    assign too_big    = len_too_big(word_next, ADDR_W);
    // Full-width compare so N = 2^ADDR_W terminates even though the address wraps.
    assign last_write = we_reg && ((written_reg + 32'd1) == count_reg);

    byte_packer u_packer (
        .clk        (clk),
        .srst       (rst),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_data  (rx_data),
        .word_next  (word_next),
        .word_full  (word_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_FIN: begin
                if (start) state_next = ST_LEN;
            end
            ST_LEN: begin
                if (word_full) begin
                    if (word_next == 32'd0 || too_big) state_next = ST_ACK;
                    else                               state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_write) state_next = ST_ACK;
            end
            ST_ACK: begin
                if (tx_ready) state_next = ST_FIN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_reg == ST_LEN) || (state_reg == ST_DATA) || (state_reg == ST_ACK);
        done     = (state_reg == ST_FIN);
        tx_valid = (state_reg == ST_ACK);
        tx_data  = (state_reg == ST_ACK) ? code_reg : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg   <= '0;
            written_reg <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            we_reg      <= 1'b0;
            err_reg     <= 1'b0;
            code_reg    <= 8'h00;
        end else begin
            we_reg <= (state_reg == ST_DATA) && word_full;
            if (state_reg == ST_DATA && word_full) begin
                wdata_reg <= word_next;
            end
            if (we_reg) begin
                addr_reg    <= addr_reg + ADDR_W'(1);
                written_reg <= written_reg + 32'd1;
            end
            if (state_reg == ST_LEN && word_full) begin
                count_reg <= word_next;
                err_reg   <= too_big;
                code_reg  <= too_big ? ACK_ERR : ACK_OK;
            end
            if (pk_clear) begin
                count_reg   <= '0;
                written_reg <= '0;
                addr_reg    <= '0;
                err_reg     <= 1'b0;
                code_reg    <= ACK_OK;
            end
        end
    end

    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign err        = err_reg;

endmodule
